core_arbiter_multi: RTL

N-channel bus arbiter, the parametrised successor to the two-port (insn/data) core arbiter. Sits between the core's requesters (fetch, load/store, future DMA or cache-refill ports) and the single external bus. Latches one outstanding request per channel. Grants the bus by fixed or round-robin priority, runs one bus transaction at a time, and returns read data and a completion pulse to the owning channel.

---
 rtl/core_arbiter_multi.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/core_arbiter_multi.sv
// N-channel bus arbiter: one pending slot per requester, fixed or round-robin grant, one bus transaction at a time.
// Optional watchdog on stalled transactions: define ARB_TIMEOUT_EN (adds the bus_err port).
module core_arbiter_multi #(
   parameter int N       = 2,
   parameter int ADDR_W  = 30,
   parameter int PRIO_RR = 0,
   localparam int GW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req_start,
   input  logic [N-1:0]        req_write,
   input  logic [N*ADDR_W-1:0] req_addr,
   input  logic [N*32-1:0]     req_data_wr,
   input  logic [N*4-1:0]      req_data_be,
   output logic [N-1:0]        req_ready,
   output logic [31:0]         req_data_rd,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic                bus_start,
   output logic                bus_write,
   output logic [31:0]         bus_data_wr,
   output logic [3:0]          bus_data_be,
   input  logic                bus_ready,
   input  logic [31:0]         bus_data_rd,
   output logic [GW-1:0]       grant
`ifdef ARB_TIMEOUT_EN
   ,output logic               bus_err
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                    state, state_nx;
   logic [N-1:0]              pend, slot_write;
   logic [N-1:0][ADDR_W-1:0]  slot_addr;
   logic [N-1:0][31:0]        slot_data;
   logic [N-1:0][3:0]         slot_be;
   logic [GW-1:0]             rr_ptr, win;
   logic                      win_vld, done, timeout;

`ifdef ARB_TIMEOUT_EN
   logic [15:0] wdog;
   assign timeout = (state == BUSY) && !bus_ready && (wdog == 16'hFFFF);
`else
   assign timeout = 1'b0;
`endif

   assign done    = (state == BUSY) && (bus_ready || timeout);
   assign win_vld = |pend;

   // Scan from the highest offset down so the first set bit at/after the base wins.
   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (PRIO_RR != 0) ? (int'(rr_ptr) + k) % N : k;
         if (pend[GW'(idx)]) win = GW'(idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (win_vld) state_nx = BUSY;
         BUSY:    if (done)    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Pending slots; the owning slot is always pending, so a completion never races a new latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         slot_write <= '0;
         slot_addr  <= '0;
         slot_data  <= '0;
         slot_be    <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (done && grant == GW'(i)) begin
               pend[i] <= 1'b0;
            end else if (req_start[i] && !pend[i]) begin
               pend[i]       <= 1'b1;
               slot_write[i] <= req_write[i];
               slot_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
               slot_data[i]  <= req_data_wr[i*32 +: 32];
               slot_be[i]    <= req_data_be[i*4 +: 4];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_start   <= 1'b0;
         bus_write   <= 1'b0;
         bus_addr    <= '0;
         bus_data_wr <= '0;
         bus_data_be <= '0;
         grant       <= '0;
         rr_ptr      <= '0;
         req_ready   <= '0;
         req_data_rd <= '0;
      end else begin
         bus_start <= 1'b0;
         req_ready <= '0;
         if (state == IDLE && win_vld) begin
            bus_start   <= 1'b1;
            bus_write   <= slot_write[win];
            bus_addr    <= slot_addr[win];
            bus_data_wr <= slot_data[win];
            bus_data_be <= slot_be[win];
            grant       <= win;
         end
         if (done) begin
            req_ready[grant] <= 1'b1;
            req_data_rd      <= timeout ? 32'hDEADBEEF : bus_data_rd;
            if (PRIO_RR != 0)
               rr_ptr <= (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog    <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= timeout;
         if (state == IDLE && win_vld)            wdog <= '0;
         else if (state == BUSY && !bus_ready)    wdog <= wdog + 16'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n) (req_start & pend) == '0);
`endif

endmodule
